// File: rtl/ser_pkg.sv
// ser_pkg: shared serializer state encoding and default word width,
// also importable by the downstream sequence detectors for bench constants.
package ser_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} ser_state_t;
    localparam int SER_DATA_W = 8;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel word to serial bit stream with a one-word holding register.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = SER_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, hold_q, hold_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              hold_full_q, hold_full_d;
    logic              accept, load, head;
    logic [DATA_W-1:0] shifted;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign in_ready = reset & ~hold_full_q;
    assign accept   = in_valid & in_ready;
    assign head     = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
    assign shifted  = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: load = hold_full_q;
            SHIFT: begin
                if (cnt_q != LAST) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = PARITY;
                    shreg_d = '0;
                    cnt_d   = '0;
`else
                    load    = hold_full_q;
                    state_d = IDLE;
                    shreg_d = '0;
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
`ifdef BIT_SERIALIZER_PARITY_EN
                load = hold_full_q;
`endif
                state_d = IDLE;
            end
        endcase
        // A pending word overrides the return to IDLE, so frames abut with no gap
        if (load) begin
            state_d     = SHIFT;
            shreg_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_d    = ^hold_q;
`endif
        end
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign out_valid = state_q != IDLE;
    assign busy      = (state_q != IDLE) | hold_full_q;
`ifdef BIT_SERIALIZER_PARITY_EN
    assign out_bit   = (state_q == SHIFT) ? head : (state_q == PARITY) & parity_q;
    assign out_last  = state_q == PARITY;
`else
    assign out_bit   = (state_q == SHIFT) & head;
    assign out_last  = (state_q == SHIFT) & (cnt_q == LAST);
`endif
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of bit_serializer in MSB-first and LSB-first builds.
module tb_bit_serializer;
    import ser_pkg::*;
    localparam int W = SER_DATA_W;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic ir0, ob0, ov0, ol0, bz0;
    logic ir1, ob1, ov1, ol1, bz1;
    int n_vec = 0, n_err = 0;

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir0), .out_bit(ob0), .out_valid(ov0), .out_last(ol0), .busy(bz0));
    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir1), .out_bit(ob1), .out_valid(ov1), .out_last(ol1), .busy(bz1));

    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
        if (i >= W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction

    task automatic send(input logic [W-1:0] w);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!ir0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (ir0 !== 1'b1) begin
            $display("FAIL send_timeout in_ready=%b required 1", ir0);
            n_err++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_frame(input string nm, input logic [W-1:0] w, input bit msb, output logic [W:0] got);
        logic [2:0] o, e;
        got = '0;
        @(negedge clk);
        n_vec++;
        if ({msb ? ov0 : ov1, msb ? bz0 : bz1} !== 2'b01) begin
            $display("FAIL %s_gap valid,busy=%b required 01", nm, {msb ? ov0 : ov1, msb ? bz0 : bz1});
            n_err++;
        end
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            o = msb ? {ov0, ob0, ol0} : {ov1, ob1, ol1};
            e = {1'b1, exp_bit(w, i, msb), i == FL - 1};
            got[i] = o[1];
            n_vec++;
            if (o !== e) begin
                $display("FAIL %s_bit%0d valid,bit,last=%b required %b", nm, i, o, e);
                n_err++;
            end
        end
        @(negedge clk);
        n_vec++;
        if ({msb ? ov0 : ov1, msb ? bz0 : bz1} !== 2'b00) begin
            $display("FAIL %s_end valid,busy=%b required 00", nm, {msb ? ov0 : ov1, msb ? bz0 : bz1});
            n_err++;
        end
    endtask

    task automatic test_reset;
        #2;
        n_vec++;
        if ({ir0, ov0, ob0, ol0, bz0} !== 5'b0) begin
            $display("FAIL reset_hold ready,valid,bit,last,busy=%b required 00000", {ir0, ov0, ob0, ol0, bz0});
            n_err++;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ov0, ob0, ir0, bz0} !== 4'b0010) begin
                $display("FAIL idle%0d valid,bit,ready,busy=%b required 0010", i, {ov0, ob0, ir0, bz0});
                n_err++;
            end
        end
    endtask

    task automatic test_a5;
        logic [W:0] got;
        logic [2:0] sh = '0;
        logic [7:0] hits = '0;
        send(8'hA5);
        check_frame("a5", 8'hA5, 1'b1, got);
        for (int i = 0; i < W; i++) begin
            sh = {sh[1:0], got[i]};
            hits[i] = (i >= 2) && (sh == 3'b101);
        end
        n_vec++;
        if (hits !== 8'b1000_0100) begin
            $display("FAIL a5_detect101 hits=%b required 10000100", hits);
            n_err++;
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] o, e;
        logic [W-1:0] w;
        @(negedge clk);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        n_vec++;
        if (ir0 !== 1'b1) begin
            $display("FAIL b2b_ready0 in_ready=%b required 1", ir0);
            n_err++;
        end
        @(posedge clk);
        #1 in_data = 8'h00;
        @(negedge clk);
        n_vec++;
        if ({ir0, ov0, bz0} !== 3'b001) begin
            $display("FAIL b2b_held ready,valid,busy=%b required 001", {ir0, ov0, bz0});
            n_err++;
        end
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            w = (i < FL) ? 8'hFF : 8'h00;
            o = {ov0, ob0, ol0};
            e = {1'b1, exp_bit(w, i % FL, 1'b1), (i % FL) == FL - 1};
            n_vec++;
            if (o !== e) begin
                $display("FAIL b2b_bit%0d valid,bit,last=%b required %b", i, o, e);
                n_err++;
            end
            if (i < 2) begin
                n_vec++;
                if (ir0 !== (i == 0)) begin
                    $display("FAIL b2b_ready%0d in_ready=%b required %b", i, ir0, i == 0);
                    n_err++;
                end
            end
            if (i == 1) in_valid = 1'b0;
        end
        @(negedge clk);
        n_vec++;
        if ({ov0, bz0} !== 2'b00) begin
            $display("FAIL b2b_end valid,busy=%b required 00", {ov0, bz0});
            n_err++;
        end
    endtask

    task automatic test_reset_mid;
        logic [W:0] got;
        @(negedge clk);
        send(8'hC3);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ov0, ob0} !== {1'b1, exp_bit(8'hC3, i, 1'b1)}) begin
                $display("FAIL c3_bit%0d valid,bit=%b required %b", i, {ov0, ob0}, {1'b1, exp_bit(8'hC3, i, 1'b1)});
                n_err++;
            end
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({ov0, ob0, ol0, bz0, ir0} !== 5'b0) begin
            $display("FAIL midreset valid,bit,last,busy,ready=%b required 00000", {ov0, ob0, ol0, bz0, ir0});
            n_err++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({ov0, bz0, ir0} !== 3'b001) begin
            $display("FAIL postreset valid,busy,ready=%b required 001", {ov0, bz0, ir0});
            n_err++;
        end
        @(negedge clk);
        send(8'h81);
        check_frame("r81", 8'h81, 1'b1, got);
    endtask

    task automatic test_lsb_first;
        logic [W:0] got;
        @(negedge clk);
        send(8'h01);
        check_frame("lsb01", 8'h01, 1'b0, got);
    endtask

    task automatic test_parity;
        logic [W:0] got;
        @(negedge clk);
        send(8'h07);
        check_frame("p07", 8'h07, 1'b1, got);
        @(negedge clk);
        send(8'h03);
        check_frame("p03", 8'h03, 1'b1, got);
    endtask

    initial begin
        test_reset;
        test_a5;
        test_back_to_back;
        test_reset_mid;
        test_lsb_first;
        test_parity;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream stage for the Moore/Mealy sequence detectors.
- Accepts parallel words over a valid/ready handshake and emits them one bit per clock on a serial output. That output connects directly to the detector's `in` port.
- Contains a one-word holding register, so back-to-back words stream with no idle cycle between frames.
- Provides frame-boundary and activity flags.

Parameters:
- DATA_W, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = shift out bit DATA_W-1 first; 0 = shift out bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_data  input  DATA_W  parallel word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_bit  output  1  serial bit; connects to the detector's `in`.
- out_valid  output  1  out_bit carries frame data this cycle.
- out_last  output  1  final bit of the current frame.
- busy  output  1  shifting, or holding register full.

Behaviour:
- Reset (reset=0, asynchronous) forces the following immediately, including mid-frame:
  - state=IDLE; shift register=0; bit counter=0; hold_full=0.
  - out_bit=0, out_valid=0, out_last=0, busy=0.
  - in_ready=0 while reset=0.
  - Any partially sent frame is discarded; no resume.
- in_ready = reset & ~hold_full, driven combinationally from registers only and never from in_valid.
- A word is accepted on a rising edge where in_valid & in_ready. It is stored in the holding register and hold_full is set.
- While hold_full=1 and in_ready=0, in_valid/in_data are ignored. The upstream must hold them stable.
- States: IDLE, SHIFT; PARITY exists only with the optional feature.
  - IDLE -> SHIFT on the edge where hold_full=1. The holding word loads into the shift register, the counter clears to 0, and hold_full clears on the same edge.
  - SHIFT: out_valid=1; out_bit = current MSB (or LSB) of the shift register. Each edge shifts by one and increments the counter.
  - SHIFT when counter==DATA_W-1 (final data bit):
    - with hold_full=1: reload from the holding register, counter=0, stay in SHIFT. There is no gap between frames.
    - with hold_full=0: go to IDLE.
- Latency:
  - Accept at edge k means IDLE loads at edge k+1.
  - The first bit is visible on out_bit during the cycle following edge k+1.
  - Frame length is exactly DATA_W cycles of out_valid=1.
- out_last=1 only on the final bit cycle of a frame.
- busy = (state!=IDLE) | hold_full.
- In IDLE: out_bit=0, out_valid=0.
- A simultaneous accept and reload cannot occur, because in_ready=0 whenever hold_full=1. A word accepted during the final bit cycle of a frame lands in the holding register on that edge. The IDLE load then follows one cycle later, giving a one-cycle gap.
- Sustained throughput is one word per DATA_W cycles once the holding register is primed.
- The counter is $clog2(DATA_W) bits and never wraps past DATA_W-1.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of the word) is captured at load.
  - After the final data bit, the FSM enters PARITY for one cycle with out_bit=parity, out_valid=1, out_last=1.
  - Data bits then have out_last=0.
  - Frame length is DATA_W+1.
  - Reload from the holding register occurs at the end of PARITY.
- When undefined: there is no PARITY state or parity logic, and out_last marks the final data bit.

Decomposition:
- Shared package ser_pkg holds:
  - the state enum ser_state_t {IDLE, SHIFT, PARITY};
  - default width constant SER_DATA_W=8.
- Sequence detectors may import the package for bench constants.
- Single module; no sub-module. The holding register and counter are small enough to stay inline.

Test Plan:
- Reset then idle, no in_valid → out_valid=0, out_bit=0, in_ready=1, busy=0 for 20 cycles.
- Send 8'hA5 with MSB_FIRST=1 → out_bit sequence 1,0,1,0,0,1,0,1 starting 2 cycles after accept; out_last on the 8th bit; the attached detector (pattern 101) asserts at the expected positions.
- Back-to-back 8'hFF then 8'h00 with in_valid held → 16 consecutive out_valid=1 cycles, no gap; in_ready low while the holding register is full.
- Drive reset=0 at bit 4 of 8'hC3 → outputs clear immediately; after release, the next word 8'h81 emits 1,0,0,0,0,0,0,1 cleanly.
- MSB_FIRST=0 with word 8'h01 → first bit 1, then seven 0s.
- With BIT_SERIALIZER_PARITY_EN, send 8'h07 → 9-bit frame ending in parity bit 1, out_last on bit 9; 8'h03 → parity bit 0.
